// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters and data_mem.
// The slave modport is the arbiter's view. The master modport is the
// environment's view: both requesters plus the memory read-data return.
interface dmem_arbiter_if;
    // Port 0 (CPU load/store)
    logic        req0;
    logic        we0;
    logic [31:0] addr0;
    logic [31:0] wdata0;
    logic        ack0;
    logic        err0;
    logic [31:0] rdata0;

    // Port 1 (debug / DMA)
    logic        req1;
    logic        we1;
    logic [31:0] addr1;
    logic [31:0] wdata1;
    logic        ack1;
    logic        err1;
    logic [31:0] rdata1;

    // data_mem side
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // Status
    logic [1:0]  grant;
    logic        cpu_stall;

    modport slave (
        input  req0, we0, addr0, wdata0,
        output ack0, err0, rdata0,
        input  req1, we1, addr1, wdata1,
        output ack1, err1, rdata1,
        output mem_write, mem_addr, mem_wdata,
        input  mem_rdata,
        output grant, cpu_stall
    );

    modport master (
        output req0, we0, addr0, wdata0,
        input  ack0, err0, rdata0,
        output req1, we1, addr1, wdata1,
        input  ack1, err1, rdata1,
        input  mem_write, mem_addr, mem_wdata,
        output mem_rdata,
        input  grant, cpu_stall
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single-port word data memory.
// Port 0 is the CPU load/store path, port 1 the debug/DMA master. Each
// transaction runs IDLE (sample + grant) -> ACCESS (one memory cycle) ->
// RESP (registered ack/err/rdata to the owner), so at most one transaction
// completes every three cycles.
module dmem_arbiter #(
    parameter int DEPTH        = 256,
    parameter int CPU_PRIORITY = 0
) (
    input  logic          clk,
    input  logic          reset_n,
    dmem_arbiter_if.slave bus
);

    localparam logic [1:0]  ST_IDLE    = 2'b00;
    localparam logic [1:0]  ST_ACCESS  = 2'b01;
    localparam logic [1:0]  ST_RESP    = 2'b10;

    // One past the last valid byte address; 33 bits so DEPTH*4 never wraps.
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH) << 2;

    // Misaligned or beyond the end of memory (unsigned, no wrap-around).
    function automatic logic addr_err(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || ({1'b0, addr} >= ADDR_LIMIT);
    endfunction

    logic [1:0]  state_q,      state_d;
    logic        last_grant_q, last_grant_d;   // 0 = port 0, 1 = port 1
    logic [31:0] addr_l_q,     addr_l_d;
    logic        we_l_q,       we_l_d;
    logic [31:0] wdata_l_q,    wdata_l_d;
    logic        owner_q,      owner_d;        // 0 = port 0, 1 = port 1
    logic        err_l_q,      err_l_d;
    logic [31:0] rdata_q,      rdata_d;
    logic [1:0]  grant_q,      grant_d;

    logic        any_req;
    logic        win_port;
    logic [31:0] sel_addr;
    logic        sel_we;
    logic [31:0] sel_wdata;
    logic        in_access;
    logic        in_resp;
    logic        resp0;
    logic        resp1;

    // Pick the winning port among the current requests.
    always_comb begin
        any_req  = bus.req0 | bus.req1;
        win_port = 1'b0;
        if (bus.req0 && bus.req1) begin
            // Tie: fixed priority favours the CPU; round-robin favours the
            // port that was not granted last time.
            if (CPU_PRIORITY != 0) begin
                win_port = 1'b0;
            end else begin
                win_port = ~last_grant_q;
            end
        end else if (bus.req1) begin
            win_port = 1'b1;
        end
    end

    // Route the winner's request fields toward the latch.
    always_comb begin
        sel_addr  = win_port ? bus.addr1  : bus.addr0;
        sel_we    = win_port ? bus.we1    : bus.we0;
        sel_wdata = win_port ? bus.wdata1 : bus.wdata0;
    end

    // FSM next-state and latch updates.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_l_d     = addr_l_q;
        we_l_d       = we_l_q;
        wdata_l_d    = wdata_l_q;
        owner_d      = owner_q;
        err_l_d      = err_l_q;
        rdata_d      = rdata_q;
        grant_d      = grant_q;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d      = ST_ACCESS;
                    addr_l_d     = sel_addr;
                    we_l_d       = sel_we;
                    wdata_l_d    = sel_wdata;
                    owner_d      = win_port;
                    err_l_d      = addr_err(sel_addr);
                    last_grant_d = win_port;
                    grant_d      = win_port ? 2'b10 : 2'b01;
                end
            end
            ST_ACCESS: begin
                state_d = ST_RESP;
                // Only a clean read returns memory data; writes and errors
                // respond with zero.
                if (!we_l_q && !err_l_q) begin
                    rdata_d = bus.mem_rdata;
                end else begin
                    rdata_d = 32'h0;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    // State and latch registers; everything clears on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            addr_l_q     <= 32'h0;
            we_l_q       <= 1'b0;
            wdata_l_q    <= 32'h0;
            owner_q      <= 1'b0;
            err_l_q      <= 1'b0;
            rdata_q      <= 32'h0;
            grant_q      <= 2'b00;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_l_q     <= addr_l_d;
            we_l_q       <= we_l_d;
            wdata_l_q    <= wdata_l_d;
            owner_q      <= owner_d;
            err_l_q      <= err_l_d;
            rdata_q      <= rdata_d;
            grant_q      <= grant_d;
        end
    end

    // Output decode; mem_write follows the state register so an async reset
    // kills it mid-ACCESS before the commit edge.
    always_comb begin
        in_access     = (state_q == ST_ACCESS);
        in_resp       = (state_q == ST_RESP);
        resp0         = in_resp & ~owner_q;
        resp1         = in_resp &  owner_q;

        bus.mem_write = in_access & we_l_q & ~err_l_q;
        bus.mem_addr  = addr_l_q;
        bus.mem_wdata = wdata_l_q;

        bus.ack0      = resp0;
        bus.err0      = resp0 & err_l_q;
        bus.rdata0    = resp0 ? rdata_q : 32'h0;
        bus.ack1      = resp1;
        bus.err1      = resp1 & err_l_q;
        bus.rdata1    = resp1 ? rdata_q : 32'h0;

        bus.grant     = grant_q;
        bus.cpu_stall = bus.req0 & ~resp0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a transaction-timeline model of the arbiter plus a
// word memory, checked against the round-robin instance every cycle, with
// directed scenarios pinning latencies, data and error responses. A second
// fixed-priority instance shares the stimulus to check its grant order.
module tb_dmem_arbiter;

    localparam int DEPTH = 256;
    localparam int IW    = $clog2(DEPTH);

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if bus();
    dmem_arbiter_if bus_fp();

    dmem_arbiter #(.DEPTH(DEPTH), .CPU_PRIORITY(0)) u_dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );
    dmem_arbiter #(.DEPTH(DEPTH), .CPU_PRIORITY(1)) u_dut_fp (
        .clk(clk), .reset_n(reset_n), .bus(bus_fp)
    );

    // Word memory behind the round-robin instance.
    bit [31:0] mem [DEPTH];
    always @(posedge clk)
        if (bus.mem_write && bus.mem_addr < 32'(DEPTH * 4))
            mem[bus.mem_addr[IW+1:2]] <= bus.mem_wdata;
    assign bus.mem_rdata    = (bus.mem_addr < 32'(DEPTH * 4)) ? mem[bus.mem_addr[IW+1:2]] : 32'h0;
    assign bus_fp.mem_rdata = 32'h0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-timeline model ----------------
    // A transaction granted at edge e occupies the next cycle as its memory
    // cycle and the one after as its response cycle; the next grant may be
    // taken no earlier than three edges later.
    int        cyc;
    int        m_t;
    int        m_free;
    bit        m_valid, m_last, m_own, m_we, m_err;
    bit [31:0] m_addr, m_wdata, m_rd;
    bit [31:0] mmem [DEPTH];

    bit        p_own, p_we, p_err;
    bit [31:0] p_addr, p_wdata;
    assign p_own   = (bus.req0 && bus.req1) ? !m_last : bus.req1;
    assign p_addr  = p_own ? bus.addr1  : bus.addr0;
    assign p_we    = p_own ? bus.we1    : bus.we0;
    assign p_wdata = p_own ? bus.wdata1 : bus.wdata0;
    assign p_err   = (p_addr % 4 != 0) || (p_addr >= 32'(DEPTH * 4));

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc <= 0; m_valid <= 0; m_free <= 0; m_last <= 1; m_own <= 0;
            m_we <= 0; m_err <= 0; m_addr <= 0; m_wdata <= 0; m_rd <= 0; m_t <= 0;
        end else begin
            cyc <= cyc + 1;
            if (m_valid && cyc == m_t && m_we && !m_err)
                mmem[m_addr[IW+1:2]] <= m_wdata;
            if (cyc >= m_free && (bus.req0 || bus.req1)) begin
                m_valid <= 1; m_t <= cyc + 1; m_free <= cyc + 3;
                m_own <= p_own; m_last <= p_own; m_addr <= p_addr;
                m_we <= p_we; m_wdata <= p_wdata; m_err <= p_err;
                m_rd <= (p_we || p_err) ? 32'h0 : mmem[p_addr[IW+1:2]];
            end
        end
    end

    logic         e_acc, e_rsp, e_ack0, e_ack1;
    logic [135:0] e_vec, a_vec;
    assign e_acc  = m_valid && (cyc == m_t);
    assign e_rsp  = m_valid && (cyc == m_t + 1);
    assign e_ack0 = e_rsp && !m_own;
    assign e_ack1 = e_rsp && m_own;
    assign e_vec  = {(e_acc || e_rsp) ? (m_own ? 2'b10 : 2'b01) : 2'b00,
                     e_acc && m_we && !m_err, m_addr, m_wdata,
                     e_ack0, e_ack0 && m_err, e_ack0 ? m_rd : 32'h0,
                     e_ack1, e_ack1 && m_err, e_ack1 ? m_rd : 32'h0,
                     bus.req0 && !e_ack0};
    assign a_vec  = {bus.grant, bus.mem_write, bus.mem_addr, bus.mem_wdata,
                     bus.ack0, bus.err0, bus.rdata0,
                     bus.ack1, bus.err1, bus.rdata1, bus.cpu_stall};

    // Per-cycle compare against the model.
    always @(negedge clk) chk("cycle_outputs", a_vec, e_vec);

    // ---------------- directed stimulus ----------------
    int          ack0_cyc, ack1_cyc;
    logic [31:0] rd0, rd1;
    logic        er0, er1, mw_seen;
    logic [1:0]  g_at [4];
    logic        stall_at [4];
    logic [31:0] maddr_at [4];
    int          ord_rr[$];
    int          ord_fp[$];

    task automatic drive_reqs(input bit r0, r1, f0, f1);
        bus.req0 = r0; bus.req1 = r1; bus_fp.req0 = f0; bus_fp.req1 = f1;
    endtask

    task automatic do_reset();
        drive_reqs(0, 0, 0, 0);
        reset_n = 1'b0;
        #1;
        chk("rst_grant", 136'(bus.grant), 136'(0));
        chk("rst_outs", 136'({bus.mem_write, bus.ack0, bus.ack1, bus.err0, bus.err1, bus.cpu_stall}), 136'(0));
        chk("rst_mem_addr", 136'(bus.mem_addr), 136'(0));
        @(posedge clk); @(posedge clk); #2;
        reset_n = 1'b1;
    endtask

    // Hold each port's request until it has been acked n0/n1 times.
    task automatic run_reqs(input int n0, n1, input bit w0, input logic [31:0] a0, d0,
                            input bit w1, input logic [31:0] a1, d1, input int maxcyc);
        int r0 = n0, r1 = n1, f0 = n0, f1 = n1, c = 0;
        ack0_cyc = -1; ack1_cyc = -1; mw_seen = 0; rd0 = 0; rd1 = 0; er0 = 0; er1 = 0;
        ord_rr.delete(); ord_fp.delete();
        bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
        bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
        bus_fp.we0 = w0; bus_fp.addr0 = a0; bus_fp.wdata0 = d0;
        bus_fp.we1 = w1; bus_fp.addr1 = a1; bus_fp.wdata1 = d1;
        drive_reqs(r0 > 0, r1 > 0, f0 > 0, f1 > 0);
        while (c < maxcyc && (r0 > 0 || r1 > 0 || f0 > 0 || f1 > 0)) begin
            @(negedge clk);
            if (c < 4) begin
                g_at[c] = bus.grant; stall_at[c] = bus.cpu_stall; maddr_at[c] = bus.mem_addr;
            end
            if (bus.mem_write) mw_seen = 1;
            if (bus.ack0) begin
                if (ack0_cyc < 0) begin ack0_cyc = c; rd0 = bus.rdata0; er0 = bus.err0; end
                ord_rr.push_back(0); r0--;
            end
            if (bus.ack1) begin
                if (ack1_cyc < 0) begin ack1_cyc = c; rd1 = bus.rdata1; er1 = bus.err1; end
                ord_rr.push_back(1); r1--;
            end
            if (bus_fp.ack0) begin ord_fp.push_back(0); f0--; end
            if (bus_fp.ack1) begin ord_fp.push_back(1); f1--; end
            @(posedge clk); #2;
            drive_reqs(r0 > 0, r1 > 0, f0 > 0, f1 > 0);
            c++;
        end
        chk("txn_pending_at_timeout", 136'((r0 > 0) + (r1 > 0) + (f0 > 0) + (f1 > 0)), 136'(0));
        drive_reqs(0, 0, 0, 0);
    endtask

    initial begin
        bus.we0 = 0; bus.addr0 = 0; bus.wdata0 = 0; bus.we1 = 0; bus.addr1 = 0; bus.wdata1 = 0;
        bus_fp.we0 = 0; bus_fp.addr0 = 0; bus_fp.wdata0 = 0;
        bus_fp.we1 = 0; bus_fp.addr1 = 0; bus_fp.wdata1 = 0;
        drive_reqs(0, 0, 0, 0);
        #1;
        do_reset();

        // Preload word 4 through port 1, then a port 0 read of it.
        run_reqs(0, 1, 0, 0, 0, 1, 32'h10, 32'hDEADBEEF, 20);
        chk("preload_ack1_cyc", 136'(ack1_cyc), 136'(2));
        run_reqs(1, 0, 0, 32'h10, 0, 0, 0, 0, 20);
        chk("rd_ack0_cyc", 136'(ack0_cyc), 136'(2));
        chk("rd_rdata0", 136'(rd0), 136'(32'hDEADBEEF));
        chk("rd_err0", 136'(er0), 136'(0));
        chk("rd_mem_addr_c1", 136'(maddr_at[1]), 136'(32'h10));
        chk("rd_grant_c1", 136'(g_at[1]), 136'(2'b01));
        chk("rd_grant_c2", 136'(g_at[2]), 136'(2'b01));
        chk("rd_stall_c0", 136'(stall_at[0]), 136'(1));
        chk("rd_stall_c2", 136'(stall_at[2]), 136'(0));
        chk("rd_no_write", 136'(mw_seen), 136'(0));

        // Simultaneous writes after reset: port 0 first, port 1 three cycles later.
        do_reset();
        run_reqs(1, 1, 1, 32'h0, 32'h11, 1, 32'h4, 32'h22, 20);
        chk("sim_ack0_cyc", 136'(ack0_cyc), 136'(2));
        chk("sim_ack1_cyc", 136'(ack1_cyc), 136'(5));
        chk("sim_mem_w0", 136'(mem[0]), 136'(32'h11));
        chk("sim_mem_w1", 136'(mem[1]), 136'(32'h22));

        // Both ports hold requests for four transactions each.
        do_reset();
        run_reqs(4, 4, 0, 32'h0, 0, 0, 32'h4, 0, 40);
        chk("rr_len", 136'(ord_rr.size()), 136'(8));
        chk("fp_len", 136'(ord_fp.size()), 136'(8));
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("rr_order[%0d]", i), 136'(i < ord_rr.size() ? ord_rr[i] : 9), 136'(i % 2));
            chk($sformatf("fp_order[%0d]", i), 136'(i < ord_fp.size() ? ord_fp[i] : 9), 136'(i >= 4 ? 1 : 0));
        end

        // Misaligned write on port 1 hits word 4's range but must not touch it.
        run_reqs(0, 1, 0, 0, 0, 1, 32'h12, 32'h99, 20);
        chk("mis_ack1_cyc", 136'(ack1_cyc), 136'(2));
        chk("mis_err1", 136'(er1), 136'(1));
        chk("mis_rdata1", 136'(rd1), 136'(0));
        chk("mis_no_write", 136'(mw_seen), 136'(0));
        chk("mis_mem_w4", 136'(mem[4]), 136'(32'hDEADBEEF));

        // Out-of-range reads: first word past the end and the top of the space.
        run_reqs(1, 0, 0, 32'(DEPTH * 4), 0, 0, 0, 0, 20);
        chk("oor_end_err0", 136'(er0), 136'(1));
        chk("oor_end_rdata0", 136'(rd0), 136'(0));
        run_reqs(1, 0, 0, 32'hFFFFFFFC, 0, 0, 0, 0, 20);
        chk("oor_top_ack0_cyc", 136'(ack0_cyc), 136'(2));
        chk("oor_top_err0", 136'(er0), 136'(1));
        chk("oor_top_rdata0", 136'(rd0), 136'(0));

        // Reset during the memory cycle of a write to word 2.
        run_reqs(0, 1, 0, 0, 0, 1, 32'h8, 32'hCAFE0002, 20);
        bus.we0 = 1; bus.addr0 = 32'h8; bus.wdata0 = 32'h5555;
        bus.req0 = 1;
        @(posedge clk); #2;
        chk("mid_write_active", 136'(bus.mem_write), 136'(1));
        #1;
        reset_n = 1'b0; bus.req0 = 0;
        #1;
        chk("mid_write_killed", 136'(bus.mem_write), 136'(0));
        chk("mid_grant", 136'(bus.grant), 136'(0));
        chk("mid_acks", 136'({bus.ack0, bus.ack1}), 136'(0));
        @(posedge clk); @(posedge clk); #2;
        reset_n = 1'b1;
        chk("mid_mem_w2", 136'(mem[2]), 136'(32'hCAFE0002));
        run_reqs(1, 0, 0, 32'h8, 0, 0, 0, 0, 20);
        chk("mid_rd_ack0_cyc", 136'(ack0_cyc), 136'(2));
        chk("mid_rd_rdata0", 136'(rd0), 136'(32'hCAFE0002));

        repeat (3) @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
